// File: rtl/wbu.sv
// wbu: writeback/commit stage, one commit pulse per accepted instruction.
// Define WBU_LOAD_TIMEOUT_EN to abort loads stuck in WAIT_MEM.
module wbu #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h80000000,
    parameter int               TIMEOUT  = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ex_valid_i,
    output logic            ex_ready_o,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] ex_npc_i,
    input  logic [XLEN-1:0] ex_res_i,
    input  logic [4:0]      ex_rd_i,
    input  logic            ex_rd_wen_i,
    input  logic            ex_is_load_i,
    input  logic            ex_csr_wen_i,
    input  logic [11:0]     ex_csr_addr_i,
    input  logic [XLEN-1:0] ex_csr_wdata_i,
    input  logic            lsu_rvalid_i,
    input  logic [XLEN-1:0] lsu_rdata_i,
    output logic            rf_wen_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            csr_wen_o,
    output logic [11:0]     csr_waddr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            pc_wen_o,
    output logic [XLEN-1:0] pc_o,
    output logic            commit_valid_o,
    output logic [XLEN-1:0] commit_pc_o,
    output logic            load_err_o
);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

    state_t          state;
    logic [XLEN-1:0] l_pc;
    logic [XLEN-1:0] l_npc;
    logic [4:0]      l_rd;
    logic            l_rd_wen;
    logic            l_csr_wen;
    logic [11:0]     l_csr_addr;
    logic [XLEN-1:0] l_csr_wdata;
    logic            xfer;

    assign ex_ready_o = (state == IDLE) || (state == COMMIT);
    assign xfer       = ex_valid_i & ex_ready_o;

`ifdef WBU_LOAD_TIMEOUT_EN
    logic [7:0] tmo_cnt;
`else
    assign load_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            rf_wen_o       <= 1'b0;
            rf_waddr_o     <= '0;
            rf_wdata_o     <= '0;
            csr_wen_o      <= 1'b0;
            csr_waddr_o    <= '0;
            csr_wdata_o    <= '0;
            pc_wen_o       <= 1'b0;
            pc_o           <= RESET_PC;
            commit_valid_o <= 1'b0;
            commit_pc_o    <= '0;
            l_pc           <= '0;
            l_npc          <= '0;
            l_rd           <= '0;
            l_rd_wen       <= 1'b0;
            l_csr_wen      <= 1'b0;
            l_csr_addr     <= '0;
            l_csr_wdata    <= '0;
`ifdef WBU_LOAD_TIMEOUT_EN
            tmo_cnt        <= '0;
            load_err_o     <= 1'b0;
`endif
        end else begin
            rf_wen_o       <= 1'b0;
            csr_wen_o      <= 1'b0;
            pc_wen_o       <= 1'b0;
            commit_valid_o <= 1'b0;
`ifdef WBU_LOAD_TIMEOUT_EN
            load_err_o     <= 1'b0;
`endif
            unique case (state)
                IDLE, COMMIT: begin
                    if (xfer) begin
                        l_pc        <= ex_pc_i;
                        l_npc       <= ex_npc_i;
                        l_rd        <= ex_rd_i;
                        l_rd_wen    <= ex_rd_wen_i;
                        l_csr_wen   <= ex_csr_wen_i;
                        l_csr_addr  <= ex_csr_addr_i;
                        l_csr_wdata <= ex_csr_wdata_i;
                        if (ex_is_load_i) begin
                            state <= WAIT_MEM;
`ifdef WBU_LOAD_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end else begin
                            // Non-loads commit straight from the inputs.
                            state          <= COMMIT;
                            rf_wen_o       <= ex_rd_wen_i & (ex_rd_i != 5'd0);
                            rf_waddr_o     <= ex_rd_i;
                            rf_wdata_o     <= ex_res_i;
                            csr_wen_o      <= ex_csr_wen_i;
                            csr_waddr_o    <= ex_csr_addr_i;
                            csr_wdata_o    <= ex_csr_wdata_i;
                            pc_wen_o       <= 1'b1;
                            pc_o           <= ex_npc_i;
                            commit_valid_o <= 1'b1;
                            commit_pc_o    <= ex_pc_i;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_MEM: begin
                    if (lsu_rvalid_i) begin
                        state          <= COMMIT;
                        rf_wen_o       <= l_rd_wen & (l_rd != 5'd0);
                        rf_waddr_o     <= l_rd;
                        rf_wdata_o     <= lsu_rdata_i;
                        csr_wen_o      <= l_csr_wen;
                        csr_waddr_o    <= l_csr_addr;
                        csr_wdata_o    <= l_csr_wdata;
                        pc_wen_o       <= 1'b1;
                        pc_o           <= l_npc;
                        commit_valid_o <= 1'b1;
                        commit_pc_o    <= l_pc;
`ifdef WBU_LOAD_TIMEOUT_EN
                    end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
                        // Give up on the load: retire it without a GPR write.
                        state          <= COMMIT;
                        load_err_o     <= 1'b1;
                        csr_wen_o      <= l_csr_wen;
                        csr_waddr_o    <= l_csr_addr;
                        csr_wdata_o    <= l_csr_wdata;
                        pc_wen_o       <= 1'b1;
                        pc_o           <= l_npc;
                        commit_valid_o <= 1'b1;
                        commit_pc_o    <= l_pc;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wbu.sv
// tb_wbu: directed bench for wbu with a commit scoreboard.
// Build with WBU_LOAD_TIMEOUT_EN to exercise the load timeout path.
module tb_wbu;

    typedef struct packed {
        logic        rf_wen;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        csr_wen;
        logic [11:0] caddr;
        logic [31:0] cwdata;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_npc = '0;
    logic [31:0] ex_res = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_rd_wen = 1'b0;
    logic        ex_is_load = 1'b0;
    logic        ex_csr_wen = 1'b0;
    logic [11:0] ex_csr_addr = '0;
    logic [31:0] ex_csr_wdata = '0;
    logic        lsu_rvalid = 1'b0;
    logic [31:0] lsu_rdata = '0;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        pc_wen;
    logic [31:0] pc;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        load_err;

    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    wbu dut (
        .clk_i(clk), .rst_i(rst),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
        .ex_pc_i(ex_pc), .ex_npc_i(ex_npc), .ex_res_i(ex_res),
        .ex_rd_i(ex_rd), .ex_rd_wen_i(ex_rd_wen),
        .ex_is_load_i(ex_is_load), .ex_csr_wen_i(ex_csr_wen),
        .ex_csr_addr_i(ex_csr_addr), .ex_csr_wdata_i(ex_csr_wdata),
        .lsu_rvalid_i(lsu_rvalid), .lsu_rdata_i(lsu_rdata),
        .rf_wen_o(rf_wen), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .csr_wen_o(csr_wen), .csr_waddr_o(csr_waddr),
        .csr_wdata_o(csr_wdata),
        .pc_wen_o(pc_wen), .pc_o(pc),
        .commit_valid_o(commit_valid), .commit_pc_o(commit_pc),
        .load_err_o(load_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard: every commit pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (commit_valid !== 1'b0) begin
                if (sb.size() == 0) begin
                    chk("spurious_commit", 32'(commit_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("commit_pc", commit_pc, e.pc);
                    chk("pc_o", pc, e.npc);
                    chk("pc_wen", 32'(pc_wen), 32'd1);
                    chk("rf_wen", 32'(rf_wen), 32'(e.rf_wen));
                    if (e.rf_wen) begin
                        chk("rf_waddr", 32'(rf_waddr), 32'(e.rd));
                        chk("rf_wdata", rf_wdata, e.wdata);
                    end
                    chk("csr_wen", 32'(csr_wen), 32'(e.csr_wen));
                    if (e.csr_wen) begin
                        chk("csr_waddr", 32'(csr_waddr), 32'(e.caddr));
                        chk("csr_wdata", csr_wdata, e.cwdata);
                    end
                    chk("load_err", 32'(load_err), 32'(e.err));
                end
            end else begin
                chk("idle_strobes",
                    32'({rf_wen, csr_wen, pc_wen, load_err}), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [31:0] p, input logic [31:0] np,
                        input logic [31:0] res, input logic [4:0] rd,
                        input logic rd_wen, input logic is_load,
                        input logic cw, input logic [11:0] ca,
                        input logic [31:0] cd);
        exp_t e;
        chk("ex_ready", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1;
        ex_pc = p;
        ex_npc = np;
        ex_res = res;
        ex_rd = rd;
        ex_rd_wen = rd_wen;
        ex_is_load = is_load;
        ex_csr_wen = cw;
        ex_csr_addr = ca;
        ex_csr_wdata = cd;
        if (!is_load) begin
            e = '{rf_wen: rd_wen && (rd != 5'd0), rd: rd, wdata: res,
                  csr_wen: cw, caddr: ca, cwdata: cd,
                  pc: p, npc: np, err: 1'b0};
            sb.push_back(e);
        end
        step();
        ex_valid = 1'b0;
        if (!is_load) chk("latency", 32'(commit_valid), 32'd1);
    endtask

    // Drive the LSU response for a pending load described by l.
    task automatic respond(input exp_t l, input logic [31:0] data);
        exp_t e;
        e = l;
        e.wdata = data;
        e.rf_wen = l.rf_wen && (l.rd != 5'd0);
        sb.push_back(e);
        lsu_rvalid = 1'b1;
        lsu_rdata = data;
        step();
        lsu_rvalid = 1'b0;
        chk("load_latency", 32'(commit_valid), 32'd1);
        chk("load_wdata", rf_wdata, data);
    endtask

    initial begin
        exp_t ld;
        ld = '0;

        idle(2);
        chk("rst_pc", pc, 32'h80000000);
        chk("rst_commit", 32'(commit_valid), 32'd0);
        chk("rst_commit_pc", commit_pc, 32'd0);
        chk("rst_strobes", 32'({rf_wen, csr_wen, pc_wen, load_err}), 32'd0);
        chk("rst_ready", 32'(ex_ready), 32'd1);
        rst = 1'b0;
        idle(1);

        send(32'h80000000, 32'h80000004, 32'h5, 5'd3, 1'b1, 1'b0,
             1'b0, 12'h0, 32'h0);
        idle(2);
        chk("pc_hold", pc, 32'h80000004);

        send(32'h80000004, 32'h80000008, 32'hFFFF, 5'd0, 1'b1, 1'b0,
             1'b0, 12'h0, 32'h0);
        idle(1);

        lsu_rvalid = 1'b1;
        lsu_rdata = 32'h12345678;
        step();
        lsu_rvalid = 1'b0;
        idle(1);

        send(32'h80000008, 32'h8000000C, 32'h0, 5'd7, 1'b1, 1'b1,
             1'b0, 12'h0, 32'h0);
        repeat (3) begin
            chk("wait_ready", 32'(ex_ready), 32'd0);
            step();
        end
        ld = '{rf_wen: 1'b1, rd: 5'd7, wdata: 32'h0, csr_wen: 1'b0,
               caddr: 12'h0, cwdata: 32'h0, pc: 32'h80000008,
               npc: 32'h8000000C, err: 1'b0};
        respond(ld, 32'hDEADBEEF);
        idle(1);

        send(32'h8000000C, 32'h80000100, 32'h80000010, 5'd1, 1'b1, 1'b0,
             1'b0, 12'h0, 32'h0);
        chk("jal_pc", pc, 32'h80000100);
        send(32'h80000100, 32'h80000104, 32'h7, 5'd2, 1'b1, 1'b0,
             1'b0, 12'h0, 32'h0);
        chk("addi_pc", pc, 32'h80000104);
        idle(1);

        send(32'h80000104, 32'h80000108, 32'h1800, 5'd5, 1'b1, 1'b0,
             1'b1, 12'h305, 32'h80000010);
        chk("csrrw_both", 32'({rf_wen, csr_wen}), 32'd3);
        idle(1);

        send(32'h80000108, 32'h8000010C, 32'h0, 5'd8, 1'b1, 1'b1,
             1'b0, 12'h0, 32'h0);
        idle(2);
        rst = 1'b1;
        step();
        chk("mid_rst_pc", pc, 32'h80000000);
        chk("mid_rst_commit", 32'(commit_valid), 32'd0);
        chk("mid_rst_strobes", 32'({rf_wen, csr_wen, pc_wen}), 32'd0);
        chk("mid_rst_ready", 32'(ex_ready), 32'd1);
        rst = 1'b0;
        lsu_rvalid = 1'b1;
        lsu_rdata = 32'hBAD0BAD0;
        step();
        lsu_rvalid = 1'b0;
        idle(2);

        send(32'h80000000, 32'h80000004, 32'h0, 5'd9, 1'b1, 1'b1,
             1'b1, 12'h340, 32'h55);
        ld = '{rf_wen: 1'b1, rd: 5'd9, wdata: 32'h0, csr_wen: 1'b1,
               caddr: 12'h340, cwdata: 32'h55, pc: 32'h80000000,
               npc: 32'h80000004, err: 1'b0};
`ifdef WBU_LOAD_TIMEOUT_EN
        idle(254);
        chk("tmo_early", 32'(commit_valid), 32'd0);
        ld.rf_wen = 1'b0;
        ld.err = 1'b1;
        sb.push_back(ld);
        step();
        chk("tmo_err", 32'(load_err), 32'd1);
        chk("tmo_rf_wen", 32'(rf_wen), 32'd0);
        chk("tmo_commit", 32'(commit_valid), 32'd1);
`else
        idle(300);
        chk("no_tmo_ready", 32'(ex_ready), 32'd0);
        chk("no_tmo_err", 32'(load_err), 32'd0);
        respond(ld, 32'hCAFEF00D);
`endif
        idle(2);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
